osd_regaccess_type_demux: RTL and testbench

- Sits directly upstream of the register-access stage on the module's debug input path.
- Inspects the TYPE field (bits 15:14 of the second flit) of each incoming DII packet.
- Steers the whole packet either to the register-access port (REG type) or to a bypass port (event/trace/other types).
- Buffers the two header flits, replays them to the chosen port, then streams the remaining flits cut-through until last.

---
 rtl/dii_package.sv | 17 +
 rtl/osd_regaccess_type_demux.sv | 133 +++++++++++++
 tb/tb_osd_regaccess_type_demux.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dii_package.sv
// Shared DII flit format and TYPE encodings. The demux and the register-access
// stage both use these so their routing decisions always agree.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  // TYPE lives in bits 15:14 of the second flit of every packet.
  localparam logic [1:0] TYPE_REG   = 2'b00;
  localparam logic [1:0] TYPE_PLAIN = 2'b01;
  localparam logic [1:0] TYPE_EVENT = 2'b10;
  localparam logic [1:0] TYPE_TRACE = 2'b11;

endpackage

// File: rtl/osd_regaccess_type_demux.sv
// Steers each DII packet to the register-access port or the bypass port,
// based on the TYPE field of its second flit.
module osd_regaccess_type_demux
  import dii_package::*;
#(
  parameter logic [1:0] REG_TYPE = TYPE_REG
) (
  input  logic       clk,
  input  logic       rst_n,
  input  dii_flit    debug_in,
  output logic       debug_in_ready,
  output dii_flit    out_reg,
  input  logic       out_reg_ready,
  output dii_flit    out_bypass,
  input  logic       out_bypass_ready,
  output logic [2:0] state_dbg_o
);

  // Handshake: a flit moves on any port in a cycle where valid and ready are
  // both high; valid/last/data stay stable while valid=1 and ready=0.

  typedef enum logic [2:0] {
    S_HDR0         = 3'd0,
    S_HDR1         = 3'd1,
    S_REPLAY0      = 3'd2,
    S_REPLAY0_LAST = 3'd3,
    S_REPLAY1      = 3'd4,
    S_PASS         = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        route_q, route_d;   // 1 = out_reg, 0 = out_bypass
  logic [15:0] buf0_q, buf0_d;
  logic [16:0] buf1_q, buf1_d;     // {last, data}

  dii_flit sel_flit;
  logic    in_ready;
  logic    sel_ready;

  assign sel_ready   = route_q ? out_reg_ready : out_bypass_ready;
  assign state_dbg_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR0;
      route_q <= 1'b0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    case (state_q)
      S_HDR0: begin
        if (debug_in.valid) begin
          buf0_d = debug_in.data;
          if (debug_in.last) begin
            // A lone flit has no TYPE field; it is treated as bypass traffic.
            route_d = 1'b0;
            state_d = S_REPLAY0_LAST;
          end else begin
            state_d = S_HDR1;
          end
        end
      end
      S_HDR1: begin
        if (debug_in.valid) begin
          buf1_d  = {debug_in.last, debug_in.data};
          route_d = (debug_in.data[15:14] == REG_TYPE);
          state_d = S_REPLAY0;
        end
      end
      S_REPLAY0: begin
        if (sel_ready) state_d = S_REPLAY1;
      end
      S_REPLAY0_LAST: begin
        if (sel_ready) state_d = S_HDR0;
      end
      S_REPLAY1: begin
        if (sel_ready) state_d = buf1_q[16] ? S_HDR0 : S_PASS;
      end
      S_PASS: begin
        if (debug_in.valid && sel_ready && debug_in.last) state_d = S_HDR0;
      end
      default: state_d = S_HDR0;
    endcase
  end

  always_comb begin
    sel_flit = '0;
    in_ready = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1: in_ready = 1'b1;
      S_REPLAY0: begin
        sel_flit.valid = 1'b1;
        sel_flit.data  = buf0_q;
      end
      S_REPLAY0_LAST: begin
        sel_flit.valid = 1'b1;
        sel_flit.last  = 1'b1;
        sel_flit.data  = buf0_q;
      end
      S_REPLAY1: begin
        sel_flit.valid = 1'b1;
        sel_flit.last  = buf1_q[16];
        sel_flit.data  = buf1_q[15:0];
      end
      S_PASS: begin
        sel_flit = debug_in;
        in_ready = sel_ready;
      end
      default: begin
        sel_flit = '0;
        in_ready = 1'b0;
      end
    endcase
  end

  // The reset gate keeps the input from looking ready while rst_n is low.
  assign debug_in_ready = in_ready & rst_n;
  assign out_reg        = route_q ? sel_flit : '0;
  assign out_bypass     = route_q ? '0 : sel_flit;

endmodule

// File: tb/tb_osd_regaccess_type_demux.sv
// Directed-vector bench for osd_regaccess_type_demux with a per-port
// expected-flit scoreboard.
module tb_osd_regaccess_type_demux;
  import dii_package::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  dii_flit    debug_in;
  logic       debug_in_ready;
  dii_flit    out_reg;
  logic       out_reg_ready;
  dii_flit    out_bypass;
  logic       out_bypass_ready;
  logic [2:0] state_dbg;

  osd_regaccess_type_demux dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .debug_in         (debug_in),
    .debug_in_ready   (debug_in_ready),
    .out_reg          (out_reg),
    .out_reg_ready    (out_reg_ready),
    .out_bypass       (out_bypass),
    .out_bypass_ready (out_bypass_ready),
    .state_dbg_o      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, cyc=%0d required done", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_reg_q[$];
  logic [16:0] exp_byp_q[$];
  int last_pop_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_reg.valid && out_reg_ready) begin
        if (exp_reg_q.size() == 0) check_eq("reg_unexpected", exp_reg_q.size(), 1);
        else check_eq("reg_flit", {out_reg.last, out_reg.data}, exp_reg_q.pop_front());
        last_pop_cyc = cyc;
      end
      if (out_bypass.valid && out_bypass_ready) begin
        if (exp_byp_q.size() == 0) check_eq("byp_unexpected", exp_byp_q.size(), 1);
        else check_eq("byp_flit", {out_bypass.last, out_bypass.data}, exp_byp_q.pop_front());
        last_pop_cyc = cyc;
      end
      if (out_reg.valid)    check_eq("byp_idle", out_bypass, '0);
      if (out_bypass.valid) check_eq("reg_idle", out_reg, '0);
    end
  end

  // ---------------- driver tasks ----------------
  logic [15:0] pd[8];
  int          st[8];
  int          last_stalls;

  // Call shortly after a rising edge; returns 1 time unit after the transfer edge.
  task automatic send_flit(input logic [15:0] d, input logic l);
    int waits;
    waits = 0;
    debug_in.valid = 1'b1;
    debug_in.last  = l;
    debug_in.data  = d;
    @(negedge clk);
    while (!debug_in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 200) check_eq("accept_timeout", waits, 0);
    last_stalls = waits;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int n, input bit to_reg);
    for (int i = 0; i < n; i++) begin
      if (to_reg) exp_reg_q.push_back({(i == n - 1), pd[i]});
      else        exp_byp_q.push_back({(i == n - 1), pd[i]});
    end
    for (int i = 0; i < n; i++) begin
      send_flit(pd[i], (i == n - 1));
      st[i] = last_stalls;
    end
  endtask

  task automatic idle_in();
    debug_in = '0;
  endtask

  task automatic drain_and_check(input string tag);
    repeat (10) @(posedge clk);
    #1;
    check_eq({tag, "_reg_left"}, exp_reg_q.size(), 0);
    check_eq({tag, "_byp_left"}, exp_byp_q.size(), 0);
  endtask

  task automatic wait_out_reg(input logic [15:0] d, input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (!(out_reg.valid && out_reg.data == d) && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (w >= 100) check_eq(tag, w, 0);
  endtask

  // ---------------- stimulus ----------------
  int t0;

  initial begin
    debug_in         = '0;
    out_reg_ready    = 1'b1;
    out_bypass_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out_reg", out_reg, '0);
    check_eq("rst_out_byp", out_bypass, '0);
    check_eq("rst_in_rdy", debug_in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_eq("post_rst_rdy", debug_in_ready, 1);
    check_eq("post_rst_state", state_dbg, 0);

    // 3-flit REG packet
    pd[0] = 16'h0005; pd[1] = 16'h0C21; pd[2] = 16'h0003;
    send_pkt(3, 1'b1);
    check_eq("t1_stall_f1", st[1], 0);
    check_eq("t1_stall_f2", st[2], 2);
    idle_in();
    drain_and_check("t1");

    // 4-flit EVENT packet goes to bypass
    pd[0] = 16'h0005; pd[1] = 16'h8021; pd[2] = 16'h1111; pd[3] = 16'h2222;
    send_pkt(4, 1'b0);
    check_eq("t2_stall_f2", st[2], 2);
    check_eq("t2_stall_f3", st[3], 0);
    idle_in();
    drain_and_check("t2");

    // Single-flit packet, then a 2-flit packet right behind it
    pd[0] = 16'h0007;
    send_pkt(1, 1'b0);
    pd[0] = 16'h0009; pd[1] = 16'h4001;
    send_pkt(2, 1'b0);
    check_eq("t3_next_hdr_stall", st[0], 1);
    idle_in();
    drain_and_check("t3");

    // Back-pressure on out_reg at REPLAY1 and mid-PASS
    pd[0] = 16'h0001; pd[1] = 16'h0102; pd[2] = 16'h0203; pd[3] = 16'h0304; pd[4] = 16'h0405;
    fork
      begin
        send_pkt(5, 1'b1);
        idle_in();
      end
      begin
        wait_out_reg(16'h0001, "t4_sync_r0");
        @(posedge clk);
        #1 out_reg_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_eq("t4_hold_replay1", out_reg, {1'b1, 1'b0, 16'h0102});
          check_eq("t4_hold_in_rdy", debug_in_ready, 0);
        end
        @(posedge clk);
        #1 out_reg_ready = 1'b1;
        wait_out_reg(16'h0203, "t4_sync_pass");
        @(posedge clk);
        #1 out_reg_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_eq("t4_hold_pass", out_reg, {1'b1, 1'b0, 16'h0304});
          check_eq("t4_hold_pass_rdy", debug_in_ready, 0);
        end
        @(posedge clk);
        #1 out_reg_ready = 1'b1;
      end
    join
    drain_and_check("t4");

    // Reset in the middle of a 6-flit REG packet
    exp_reg_q.push_back({1'b0, 16'h00A0});
    exp_reg_q.push_back({1'b0, 16'h0B01});
    exp_reg_q.push_back({1'b0, 16'h00A2});
    exp_reg_q.push_back({1'b0, 16'h00A3});
    send_flit(16'h00A0, 1'b0);
    send_flit(16'h0B01, 1'b0);
    send_flit(16'h00A2, 1'b0);
    send_flit(16'h00A3, 1'b0);
    debug_in.valid = 1'b1;
    debug_in.last  = 1'b0;
    debug_in.data  = 16'h4444;
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_out_reg", out_reg, '0);
    check_eq("t5_rst_out_byp", out_bypass, '0);
    check_eq("t5_rst_in_rdy", debug_in_ready, 0);
    check_eq("t5_rst_state", state_dbg, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // The leftover two flits form a new 2-flit packet; 0x8006 carries EVENT.
    exp_byp_q.push_back({1'b0, 16'h4444});
    exp_byp_q.push_back({1'b1, 16'h8006});
    send_flit(16'h4444, 1'b0);
    send_flit(16'h8006, 1'b1);
    idle_in();
    drain_and_check("t5");
    check_eq("t5_end_state", state_dbg, 0);

    // Back-to-back packets, valid held high: 3+2 + 4+2 + 2+2 = 15 cycles
    t0 = cyc;
    pd[0] = 16'h0010; pd[1] = 16'h3FFF; pd[2] = 16'h0011;
    send_pkt(3, 1'b1);
    pd[0] = 16'h0020; pd[1] = 16'hC000; pd[2] = 16'h0021; pd[3] = 16'h0022;
    send_pkt(4, 1'b0);
    pd[0] = 16'h0030; pd[1] = 16'h4000;
    send_pkt(2, 1'b0);
    idle_in();
    drain_and_check("t6");
    check_eq("t6_cycles", last_pop_cyc + 1 - t0, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
